// File: rtl/md_defs.sv
// Shared definitions for the multiply/divide sequencer: op codes, widths and FSM states.
package md_defs;

    localparam int unsigned MD_OP_W = 3;
    localparam int unsigned DATA_W  = 32;

    localparam logic [MD_OP_W-1:0] MD_NONE  = 3'd0;
    localparam logic [MD_OP_W-1:0] MD_MULT  = 3'd1;
    localparam logic [MD_OP_W-1:0] MD_MULTU = 3'd2;
    localparam logic [MD_OP_W-1:0] MD_DIV   = 3'd3;
    localparam logic [MD_OP_W-1:0] MD_DIVU  = 3'd4;
    localparam logic [MD_OP_W-1:0] MD_MTHI  = 3'd5;
    localparam logic [MD_OP_W-1:0] MD_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DIV_START = 2'd1,
        ST_DIV_WAIT  = 2'd2,
        ST_DONE      = 2'd3
    } md_state_t;

    function automatic logic is_div(input logic [MD_OP_W-1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_sequencer.sv
// Multiply/divide controller: drives the combinational multiplier, sequences the
// iterative divider, owns HI/LO and holds the pipeline while a divide is in flight.
module mdu_sequencer
    import md_defs::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 40,
    parameter int unsigned CNT_W          = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [MD_OP_W-1:0]  md_op,
    input  logic [DATA_W-1:0]   rs_data,
    input  logic [DATA_W-1:0]   rt_data,
    input  logic [2*DATA_W-1:0] mult_prod,
    output logic                mult_signed,
    output logic                div_start,
    output logic                div_signed,
    output logic [DATA_W-1:0]   div_dividend,
    output logic [DATA_W-1:0]   div_divisor,
    input  logic                div_busy,
    input  logic                div_over,
    input  logic [DATA_W-1:0]   div_q,
    input  logic [DATA_W-1:0]   div_r,
    output logic                stall,
    output logic                div_err,
    output logic [DATA_W-1:0]   hi,
    output logic [DATA_W-1:0]   lo
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    md_state_t          state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [DATA_W-1:0]  hi_nxt, lo_nxt;
    logic               err_nxt;
    logic               load_ops;

    // Completion is signalled by div_over alone; busy is informational only.
    logic unused_div_busy;
    assign unused_div_busy = div_busy;

    assign mult_signed = (md_op == MD_MULT);

    // Next-state, HI/LO update and stall decode.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        hi_nxt    = hi;
        lo_nxt    = lo;
        err_nxt   = 1'b0;
        load_ops  = 1'b0;
        stall     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (md_op == MD_MULT || md_op == MD_MULTU) begin
                    hi_nxt = mult_prod[2*DATA_W-1:DATA_W];
                    lo_nxt = mult_prod[DATA_W-1:0];
                end else if (md_op == MD_MTHI) begin
                    hi_nxt = rs_data;
                end else if (md_op == MD_MTLO) begin
                    lo_nxt = rs_data;
                end else if (is_div(md_op) && (rt_data != '0)) begin
                    stall     = 1'b1;
                    load_ops  = 1'b1;
                    state_nxt = ST_DIV_START;
                end
            end
            ST_DIV_START: begin
                stall     = 1'b1;
                cnt_nxt   = '0;
                state_nxt = ST_DIV_WAIT;
            end
            ST_DIV_WAIT: begin
                stall   = 1'b1;
                cnt_nxt = cnt + CNT_W'(1);
                if (div_over) begin
                    lo_nxt    = div_q;
                    hi_nxt    = div_r;
                    state_nxt = ST_DONE;
                end else if (cnt == CNT_LAST) begin
                    err_nxt   = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            // The retiring divide is still on md_op here and must not re-issue.
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, HI/LO, divider handshake and operand registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            hi           <= '0;
            lo           <= '0;
            div_start    <= 1'b0;
            div_err      <= 1'b0;
            div_signed   <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            hi        <= hi_nxt;
            lo        <= lo_nxt;
            div_start <= (state_nxt == ST_DIV_START);
            div_err   <= err_nxt;
            if (load_ops) begin
                div_signed   <= (md_op == MD_DIV);
                div_dividend <= rs_data;
                div_divisor  <= rt_data;
            end
        end
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Randomized self-checking bench for mdu_sequencer with a transaction-level reference model.
module tb_mdu_sequencer;
    import md_defs::*;

    localparam int unsigned TIMEOUT = 40;
    localparam int NEVER = 1000;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  md_op;
    logic [31:0] rs_data, rt_data;
    logic [63:0] mult_prod;
    logic        mult_signed, div_start, div_signed;
    logic [31:0] div_dividend, div_divisor;
    logic        div_busy, div_over;
    logic [31:0] div_q, div_r;
    logic        stall, div_err;
    logic [31:0] hi, lo;

    int tests = 0;
    int fails = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    always #5 clk = ~clk;

    mdu_sequencer #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .md_op(md_op), .rs_data(rs_data), .rt_data(rt_data),
        .mult_prod(mult_prod), .mult_signed(mult_signed), .div_start(div_start),
        .div_signed(div_signed), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_busy(div_busy), .div_over(div_over), .div_q(div_q), .div_r(div_r),
        .stall(stall), .div_err(div_err), .hi(hi), .lo(lo)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // External multiplier: full 64-bit product of the operands.
    function automatic logic [63:0] mult_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        if (op == MD_MULT) return 64'(sa * sb);
        if (op == MD_MULTU) return {32'b0, a} * {32'b0, b};
        return {$urandom, $urandom};
    endfunction

    // Presents one instruction, holds it while stalled, and checks it against the model.
    // n = divider cycles from the start pulse to the over pulse.
    task automatic run_instr(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int n);
        logic signed [31:0] sa, sb;
        logic [31:0] q, r, e_hi, e_lo;
        int e_cycles, e_err, starts, errs, start_cyc, cyc;
        bit done;
        sa = a; sb = b;
        q = '0; r = '0;
        e_hi = m_hi; e_lo = m_lo; e_cycles = 1; e_err = 0;
        if (is_div(op) && b != 0) begin
            q = (op == MD_DIV) ? 32'(sa / sb) : a / b;
            r = (op == MD_DIV) ? 32'(sa % sb) : a % b;
            if (n <= int'(TIMEOUT)) begin
                e_cycles = n + 3; e_hi = r; e_lo = q;
            end else begin
                e_cycles = int'(TIMEOUT) + 3; e_err = 1;
            end
        end else if (op == MD_MULT || op == MD_MULTU) begin
            {e_hi, e_lo} = mult_model(op, a, b);
        end else if (op == MD_MTHI) begin
            e_hi = a;
        end else if (op == MD_MTLO) begin
            e_lo = a;
        end

        @(negedge clk);
        md_op = op; rs_data = a; rt_data = b; mult_prod = mult_model(op, a, b);
        starts = 0; errs = 0; start_cyc = -1; cyc = 0; done = 0;
        while (!done && cyc < 200) begin
            div_over = (start_cyc >= 0) && (cyc == start_cyc + n);
            div_busy = (start_cyc >= 0) && (cyc > start_cyc) && (cyc <= start_cyc + n);
            div_q = div_over ? q : $urandom;
            div_r = div_over ? r : $urandom;
            #1;
            check("mult_signed", 64'(mult_signed), 64'(op == MD_MULT));
            if (div_start) begin
                starts++;
                if (start_cyc < 0) start_cyc = cyc;
                check("div_dividend", 64'(div_dividend), 64'(a));
                check("div_divisor", 64'(div_divisor), 64'(b));
                check("div_signed", 64'(div_signed), 64'(op == MD_DIV));
            end
            if (div_err) errs++;
            if (!stall) done = 1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        check("retire_cycles", 64'(cyc + 1), 64'(e_cycles));
        check("start_pulses", 64'(starts), 64'(e_cycles > 1 ? 1 : 0));
        check("err_pulses", 64'(errs), 64'(e_err));
        @(negedge clk);
        md_op = MD_NONE; div_over = 1'b0; div_busy = 1'b0;
        #1;
        m_hi = e_hi; m_lo = e_lo;
        check("hi", 64'(hi), 64'(m_hi));
        check("lo", 64'(lo), 64'(m_lo));
        check("idle_stall", 64'(stall), 64'(0));
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        int n;
        rst = 1'b1; md_op = MD_NONE; rs_data = '0; rt_data = '0; mult_prod = '0;
        div_busy = 1'b0; div_over = 1'b0; div_q = '0; div_r = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_hi", 64'(hi), 64'(0));
        check("reset_lo", 64'(lo), 64'(0));
        check("reset_stall", 64'(stall), 64'(0));
        check("reset_start", 64'(div_start), 64'(0));

        run_instr(MD_MULT, 32'hFFFF_FFFE, 32'd3, 0);
        run_instr(MD_MTHI, 32'h1234_5678, 32'd0, 0);
        run_instr(MD_MTLO, 32'h9ABC_DEF0, 32'd0, 0);
        run_instr(MD_DIVU, 32'd100, 32'd7, 33);
        run_instr(MD_DIV, 32'd5, 32'd0, 5);
        run_instr(MD_DIV, -32'sd7, 32'd2, NEVER);
        run_instr(MD_DIV, -32'sd7, 32'd2, 1);
        run_instr(MD_DIVU, 32'hFFFF_FFFF, 32'd10, 40);
        run_instr(MD_DIV, 32'd1000, -32'sd3, 41);
        run_instr(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_instr(3'd7, 32'hDEAD_BEEF, 32'd1, 0);

        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            a = $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if (op == MD_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
            n = $urandom_range(1, 48);
            if (n > 44) n = NEVER;
            run_instr(op, a, b, n);
        end

        // Reset while the divider is running; its late result must be dropped.
        @(negedge clk);
        md_op = MD_DIVU; rs_data = 32'd99; rt_data = 32'd4;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; md_op = MD_NONE;
        #1;
        check("rst_mid_stall", 64'(stall), 64'(0));
        check("rst_mid_hi", 64'(hi), 64'(0));
        check("rst_mid_lo", 64'(lo), 64'(0));
        check("rst_mid_dividend", 64'(div_dividend), 64'(0));
        check("rst_mid_divisor", 64'(div_divisor), 64'(0));
        check("rst_mid_err", 64'(div_err), 64'(0));
        @(negedge clk);
        div_over = 1'b1; div_q = 32'd24; div_r = 32'd3;
        @(negedge clk);
        div_over = 1'b0;
        #1;
        check("late_over_hi", 64'(hi), 64'(0));
        check("late_over_lo", 64'(lo), 64'(0));
        check("late_over_stall", 64'(stall), 64'(0));
        check("late_over_start", 64'(div_start), 64'(0));
        m_hi = '0; m_lo = '0;
        run_instr(MD_DIV, 32'd50, 32'd6, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
